// File: rtl/sram_march_tester_if.sv
// sram_march_tester_if: RAM-side bus between the march tester (master) and the 64x8 single-port RAM (slave)
interface sram_march_tester_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              o_ram_ce;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] i_ram_rdata;

    modport master (
        output o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
    );

    modport slave (
        input  o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/sram_march_tester.sv
// sram_march_tester: writes seed^addr and its inverse through the RAM, reads each back, reports pass/err count/first fail address
module sram_march_tester #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_seed,
    sram_march_tester_if.master ram,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [ADDR_W+1:0]   o_err_cnt,
    output logic [ADDR_W-1:0]   o_fail_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, WR0, RD0, DR0, WR1, RD1, DR1, DONE} state_t;

    state_t              r_state, w_nstate;
    logic [ADDR_W-1:0]   r_addr, w_naddr;
    logic [DATA_W-1:0]   r_seed, w_nseed;
    logic                w_accept;
    logic                r_cv;
    logic [ADDR_W-1:0]   r_caddr;
    logic                r_cinv;
    logic [DATA_W-1:0]   w_exp;
    logic                w_mis;
    logic [ADDR_W+1:0]   w_nerr;

    assign ram.o_ram_addr = r_addr;

    // Next state and next address: one address per cycle through each write/read sweep.
    always_comb begin
        w_nstate = r_state;
        w_naddr  = r_addr;
        w_accept = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_nstate = WR0;
                    w_naddr  = '0;
                end
            end
            WR0, RD0, WR1, RD1: begin
                w_naddr = r_addr + 1'b1;
                if (r_addr == LAST) begin
                    w_naddr  = '0;
                    w_nstate = r_state == WR0 ? RD0 : r_state == RD0 ? DR0 : r_state == WR1 ? RD1 : DR1;
                end
            end
            DR0:     w_nstate = WR1;
            DR1:     w_nstate = DONE;
            DONE:    w_nstate = IDLE;
            default: w_nstate = IDLE;
        endcase
        w_nseed = w_accept ? i_seed : r_seed;
    end

    // Compare the word read one cycle ago against the pattern of the address it was issued with.
    always_comb begin
        w_exp  = (DATA_W'(r_caddr) ^ r_seed) ^ {DATA_W{r_cinv}};
        w_mis  = r_cv && (ram.i_ram_rdata != w_exp);
        w_nerr = w_accept ? '0 : o_err_cnt + {{(ADDR_W+1){1'b0}}, w_mis};
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_nstate;
    end

    // Registered RAM bus, compare pipeline and run results; every output is a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr          <= '0;
            r_seed          <= '0;
            ram.o_ram_ce    <= 1'b0;
            ram.o_ram_we    <= 1'b0;
            ram.o_ram_wdata <= '0;
            r_cv            <= 1'b0;
            r_caddr         <= '0;
            r_cinv          <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_err_cnt       <= '0;
            o_fail_addr     <= '0;
        end else begin
            r_addr          <= w_naddr;
            r_seed          <= w_nseed;
            ram.o_ram_ce    <= w_nstate == WR0 || w_nstate == RD0 || w_nstate == WR1 || w_nstate == RD1;
            ram.o_ram_we    <= w_nstate == WR0 || w_nstate == WR1;
            ram.o_ram_wdata <= (DATA_W'(w_naddr) ^ w_nseed) ^ {DATA_W{w_nstate == WR1}};
            r_cv            <= r_state == RD0 || r_state == RD1;
            r_caddr         <= r_addr;
            r_cinv          <= r_state == RD1;
            o_busy          <= w_nstate != IDLE;
            o_done          <= w_nstate == DONE;
            o_pass          <= w_accept ? 1'b0 : w_nstate == DONE ? w_nerr == '0 : o_pass;
            o_err_cnt       <= w_nerr;
            o_fail_addr     <= w_accept ? '0 : (w_mis && o_err_cnt == '0) ? r_caddr : o_fail_addr;
        end
    end
endmodule

// File: tb/tb_sram_march_tester.sv
// tb_sram_march_tester: randomized runs against a faulty-RAM model, scoreboard of expected run results and write stream
module tb_sram_march_tester;
    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_seed;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_err_cnt;
    logic [5:0] o_fail_addr;

    sram_march_tester_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    sram_march_tester #(.ADDR_W(6), .DATA_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_seed      (i_seed),
        .ram         (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_err_cnt   (o_err_cnt),
        .o_fail_addr (o_fail_addr)
    );

    typedef struct {
        logic [7:0] seed;
        logic       pass;
        logic [7:0] err;
        logic [5:0] fa;
        int         c0;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wn = 0;
    int         age = 0;
    logic       h_pass = 1'b0;
    logic [7:0] h_err = '0;
    logic [5:0] h_fa = '0;

    int         f_kind = 0;
    logic [5:0] f_addr = '0;
    logic [7:0] f_mask = '0;
    logic [7:0] mem [64];
    logic [5:0] raddr = '0;

    // Fault model: 0 ideal, 1 stuck-at-1 bits at one address, 2 whole array reads 0, 3 flipped bits at one address.
    function automatic logic [7:0] fault_rd(int kind, logic [5:0] fa, logic [7:0] mask, logic [5:0] a, logic [7:0] v);
        if (kind == 1 && a == fa) return v | mask;
        if (kind == 2) return 8'h00;
        if (kind == 3 && a == fa) return v ^ mask;
        return v;
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // RAM: registered address on every ce edge, one-cycle read latency.
    always @(posedge i_clk) begin
        if (bus.o_ram_ce) begin
            if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
            raddr <= bus.o_ram_addr;
        end
    end

    always_comb bus.i_ram_rdata = fault_rd(f_kind, f_addr, f_mask, raddr, mem[raddr]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks reset values, the write stream, busy, and each run result when o_done pulses.
    always @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            #1;
            chk("rst_ce", bus.o_ram_ce, 0);
            chk("rst_we", bus.o_ram_we, 0);
            chk("rst_addr", bus.o_ram_addr, 0);
            chk("rst_wdata", bus.o_ram_wdata, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_pass", o_pass, 0);
            chk("rst_err", o_err_cnt, 0);
            chk("rst_fa", o_fail_addr, 0);
            q.delete();
            wn = 0;
            age = 0;
            h_pass = 1'b0;
            h_err = '0;
            h_fa = '0;
        end else begin
            if (q.size() != 0) age++;
            if (bus.o_ram_ce && bus.o_ram_we) begin
                if (q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    logic [7:0] a;
                    a = 8'(wn % 64);
                    chk("wr_addr", bus.o_ram_addr, a);
                    chk("wr_data", bus.o_ram_wdata, (a ^ q[0].seed) ^ (wn >= 64 ? 8'hFF : 8'h00));
                end
                wn = (wn + 1) % 128;
            end
            chk("busy", o_busy, q.size() != 0 || o_done);
            if (o_done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pass", o_pass, e.pass);
                    chk("err_cnt", o_err_cnt, e.err);
                    chk("fail_addr", o_fail_addr, e.fa);
                    chk("latency", cyc - e.c0, 258);
                    h_pass = e.pass;
                    h_err = e.err;
                    h_fa = e.fa;
                end
                age = 0;
            end else if (!o_busy && q.size() == 0) begin
                chk("hold_pass", o_pass, h_pass);
                chk("hold_err", o_err_cnt, h_err);
                chk("hold_fa", o_fail_addr, h_fa);
            end
            if (age > 400) begin
                chk("timeout_done", 0, 1);
                void'(q.pop_front());
                age = 0;
            end
        end
    end

    // Reference: march both patterns over the whole array through the fault model.
    function automatic exp_t model(logic [7:0] seed, int c0);
        exp_t e;
        e.seed = seed;
        e.err = '0;
        e.fa = '0;
        e.c0 = c0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 64; a++) begin
                logic [7:0] w;
                w = 8'(a) ^ seed ^ (p == 1 ? 8'hFF : 8'h00);
                if (fault_rd(f_kind, f_addr, f_mask, 6'(a), w) != w) begin
                    if (e.err == 0) e.fa = 6'(a);
                    e.err++;
                end
            end
        e.pass = e.err == 0;
        return e;
    endfunction

    task automatic launch(input logic [7:0] seed);
        @(negedge i_clk);
        i_seed = seed;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        q.push_back(model(seed, cyc));
    endtask

    task automatic run(input logic [7:0] seed, input int kind, input logic [5:0] fa, input logic [7:0] mask, input bit ign);
        int n;
        f_kind = kind;
        f_addr = fa;
        f_mask = mask;
        launch(seed);
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge i_clk);
            n++;
            if (ign) begin
                i_start = (n % 37 == 5);
                i_seed = 8'($urandom);
            end
        end
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b1;
        i_start = 1'b0;
        i_seed = '0;
        #2 i_rst_n = 1'b0;
        #20;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        run(8'h00, 0, 6'h00, 8'h00, 1'b0);
        run(8'hA5, 0, 6'h00, 8'h00, 1'b0);
        run(8'h00, 1, 6'h10, 8'h01, 1'b0);
        run(8'h00, 2, 6'h00, 8'h00, 1'b0);
        run(8'h00, 3, 6'h3F, 8'h80, 1'b1);
        f_kind = 0;
        launch(8'($urandom));
        repeat (100) @(negedge i_clk);
        #3 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        run(8'h3C, 0, 6'h00, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++)
            run(8'($urandom), int'($urandom_range(0, 3)), 6'($urandom), 8'($urandom_range(1, 255)), i[0]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
